// File: rtl/pc_seq_pkg.sv
// rtl/pc_seq_pkg.sv - shared constants and enums for the fetch-stage PC sequencer
// Feature macro used by this slice: PCSEQ_EXC_EN
package pc_seq_pkg;

  localparam logic [31:0] RESET_VEC = 32'h0000_3000;
  localparam logic [31:0] EXC_VEC   = 32'h0000_4180;

  typedef enum logic [1:0] {BOOT, FETCH, STALL, HALT} state_e;

  typedef enum logic [2:0] {SEQ, BR, J, JR, EXC} npc_sel_e;

endpackage

// File: rtl/pc_next_mux.sv
// rtl/pc_next_mux.sv - combinational next-PC adders and priority select
// Feature macro: PCSEQ_EXC_EN (exception / misaligned-jr redirect)
module pc_next_mux #(
  parameter logic [31:0] EXC_VEC = pc_seq_pkg::EXC_VEC
) (
  input  logic [31:0] pc,
  input  logic [31:0] pc_d,
  input  logic        br_taken,
  input  logic [15:0] br_imm,
  input  logic        j_taken,
  input  logic [25:0] j_index,
  input  logic        jr_taken,
  input  logic [31:0] jr_target,
  input  logic        exc_req,
  output logic [31:0] npc,
  output logic [2:0]  sel
);
  import pc_seq_pkg::*;

  logic [31:0] pc_plus4;
  logic [31:0] pc_d_plus4;
  logic [31:0] br_off;
  logic [31:0] npc_br;
  logic [31:0] npc_j;
  logic [31:0] jr_tgt;
  logic        exc_hit;
  npc_sel_e    sel_e;

  assign pc_plus4   = pc + 32'd4;
  assign pc_d_plus4 = pc_d + 32'd4;
  assign br_off     = {{14{br_imm[15]}}, br_imm, 2'b00};
  assign npc_br     = pc_d_plus4 + br_off;
  assign npc_j      = {pc_d_plus4[31:28], j_index, 2'b00};

`ifdef PCSEQ_EXC_EN
  assign jr_tgt  = jr_target;
  assign exc_hit = exc_req | (jr_taken & (jr_target[1:0] != 2'b00));
`else
  logic unused_in;
  assign unused_in = ^{exc_req, jr_target[1:0]};
  assign jr_tgt    = {jr_target[31:2], 2'b00};
  assign exc_hit   = 1'b0;
`endif

  // j is checked before br, so an illegal br+j pair resolves to j silently
  always_comb begin
    sel_e = SEQ;
    npc   = pc_plus4;
    if (exc_hit) begin
      sel_e = EXC;
      npc   = EXC_VEC;
    end else if (jr_taken) begin
      sel_e = JR;
      npc   = jr_tgt;
    end else if (j_taken) begin
      sel_e = J;
      npc   = npc_j;
    end else if (br_taken) begin
      sel_e = BR;
      npc   = npc_br;
    end
  end

  assign sel = sel_e;

endmodule

// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - fetch-stage sequencer: PC, fetch handshake, redirects, stall/halt
// Feature macro: PCSEQ_EXC_EN (exception redirect and live epc port)
module pc_sequencer #(
  parameter logic [31:0] RESET_VEC = pc_seq_pkg::RESET_VEC,
  parameter logic [31:0] EXC_VEC   = pc_seq_pkg::EXC_VEC
) (
  input  logic        Clk,
  input  logic        Reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        stall,
  input  logic        halt,
  input  logic        br_taken,
  input  logic [15:0] br_imm,
  input  logic        j_taken,
  input  logic [25:0] j_index,
  input  logic        jr_taken,
  input  logic [31:0] jr_target,
  input  logic        exc_req,
  output logic [31:0] pc_d,
  output logic        instr_valid,
  output logic        flush_d,
  output logic [31:0] epc
);
  import pc_seq_pkg::*;

  state_e      state, state_n;
  logic [31:0] pc, pc_n, pc_d_n;
  logic [31:0] pend_pc, pend_pc_n;
  logic        pend_v, pend_v_n;
  logic [31:0] epc_r, epc_n;
  logic        iv_n, fl_n;
  logic [31:0] npc;
  logic [2:0]  sel;
  logic        dec_ok, redir, exc_fire;

  // decode redirects only count while a fetch is live and decode is not frozen
  assign dec_ok = (state == FETCH) && !stall;

  pc_next_mux #(.EXC_VEC(EXC_VEC)) u_next (
    .pc        (pc),
    .pc_d      (pc_d),
    .br_taken  (br_taken & dec_ok),
    .br_imm    (br_imm),
    .j_taken   (j_taken & dec_ok),
    .j_index   (j_index),
    .jr_taken  (jr_taken & dec_ok),
    .jr_target (jr_target),
    .exc_req   (exc_req),
    .npc       (npc),
    .sel       (sel)
  );

  assign redir     = (sel != SEQ);
  assign exc_fire  = (sel == EXC);
  assign imem_req  = (state == FETCH);
  assign imem_addr = pc;

  always_comb begin
    state_n   = state;
    pc_n      = pc;
    pc_d_n    = pc_d;
    pend_v_n  = pend_v;
    pend_pc_n = pend_pc;
    epc_n     = epc_r;
    iv_n      = 1'b0;
    fl_n      = 1'b0;
    case (state)
      BOOT: state_n = FETCH;
      FETCH, STALL: begin
        if (exc_fire) begin
          // exceptions abort any outstanding fetch and drop a pending redirect
          state_n  = FETCH;
          pc_n     = EXC_VEC;
          epc_n    = pc_d;
          fl_n     = 1'b1;
          pend_v_n = 1'b0;
        end else if (halt) begin
          state_n = HALT;
        end else if (state == STALL) begin
          if (!stall) state_n = FETCH;
        end else if (stall) begin
          state_n = STALL;
        end else if (imem_ready) begin
          pc_n     = pend_v ? pend_pc : npc;
          pc_d_n   = pc;
          iv_n     = 1'b1;
          fl_n     = pend_v | redir;
          pend_v_n = 1'b0;
        end else if (redir && !pend_v) begin
          pend_v_n  = 1'b1;
          pend_pc_n = npc;
        end
      end
      HALT:    state_n = HALT;
      default: state_n = BOOT;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state       <= BOOT;
      pc          <= RESET_VEC;
      pc_d        <= RESET_VEC;
      pend_v      <= 1'b0;
      pend_pc     <= 32'h0;
      epc_r       <= 32'h0;
      instr_valid <= 1'b0;
      flush_d     <= 1'b0;
    end else begin
      state       <= state_n;
      pc          <= pc_n;
      pc_d        <= pc_d_n;
      pend_v      <= pend_v_n;
      pend_pc     <= pend_pc_n;
      epc_r       <= epc_n;
      instr_valid <= iv_n;
      flush_d     <= fl_n;
    end
  end

`ifdef PCSEQ_EXC_EN
  assign epc = epc_r;
`else
  logic unused_epc;
  assign unused_epc = ^epc_r;
  assign epc        = 32'h0;
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// tb/tb_pc_sequencer.sv - directed self-checking bench for pc_sequencer
module tb_pc_sequencer;

  logic        Clk = 1'b0;
  logic        Reset = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic        stall, halt;
  logic        br_taken;
  logic [15:0] br_imm;
  logic        j_taken;
  logic [25:0] j_index;
  logic        jr_taken;
  logic [31:0] jr_target;
  logic        exc_req;
  logic [31:0] pc_d;
  logic        instr_valid, flush_d;
  logic [31:0] epc;

  int passed = 0;
  int total  = 0;

  pc_sequencer dut (
    .Clk         (Clk),
    .Reset       (Reset),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ready  (imem_ready),
    .stall       (stall),
    .halt        (halt),
    .br_taken    (br_taken),
    .br_imm      (br_imm),
    .j_taken     (j_taken),
    .j_index     (j_index),
    .jr_taken    (jr_taken),
    .jr_target   (jr_target),
    .exc_req     (exc_req),
    .pc_d        (pc_d),
    .instr_valid (instr_valid),
    .flush_d     (flush_d),
    .epc         (epc)
  );

  always #5 Clk = ~Clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  logic [31:0] exp_exc_addr, exp_exc_epc, exp_exc_fl;

  initial begin
`ifdef PCSEQ_EXC_EN
    exp_exc_addr = 32'h0000_4180;
    exp_exc_epc  = 32'h0000_300C;
    exp_exc_fl   = 32'd1;
`else
    exp_exc_addr = 32'h0000_3014;
    exp_exc_epc  = 32'h0;
    exp_exc_fl   = 32'd0;
`endif
    stall = 0; halt = 0; imem_ready = 0;
    br_taken = 0; br_imm = 16'h0; j_taken = 0; j_index = 26'h0;
    jr_taken = 0; jr_target = 32'h0; exc_req = 0;
    tick(); tick();
    chk("rst_req",   imem_req,    0);
    chk("rst_addr",  imem_addr,   32'h3000);
    chk("rst_pc_d",  pc_d,        32'h3000);
    chk("rst_iv",    instr_valid, 0);
    chk("rst_fl",    flush_d,     0);
    chk("rst_epc",   epc,         0);

    // sequential fetch
    Reset = 1; imem_ready = 1;
    chk("boot_req", imem_req, 0);
    tick();
    chk("f0_req",  imem_req,    1);
    chk("f0_addr", imem_addr,   32'h3000);
    chk("f0_iv",   instr_valid, 0);
    tick();
    chk("f1_addr", imem_addr,   32'h3004);
    chk("f1_iv",   instr_valid, 1);
    chk("f1_pc_d", pc_d,        32'h3000);
    tick();
    chk("f2_addr", imem_addr,   32'h3008);
    chk("f2_iv",   instr_valid, 1);
    chk("f2_pc_d", pc_d,        32'h3004);

    // stall for 3 cycles at 3008
    stall = 1;
    tick();
    chk("s1_req",  imem_req,    0);
    chk("s1_addr", imem_addr,   32'h3008);
    chk("s1_pc_d", pc_d,        32'h3004);
    chk("s1_iv",   instr_valid, 0);
    tick(); tick();
    chk("s3_req",  imem_req,    0);
    chk("s3_addr", imem_addr,   32'h3008);
    chk("s3_pc_d", pc_d,        32'h3004);
    stall = 0;
    tick();
    chk("sx_req",  imem_req,    1);
    chk("sx_addr", imem_addr,   32'h3008);
    chk("sx_iv",   instr_valid, 0);
    tick();
    chk("sr_addr", imem_addr,   32'h300C);
    chk("sr_pc_d", pc_d,        32'h3008);
    chk("sr_iv",   instr_valid, 1);

    // backward branch from pc_d=3010
    tick(); tick();
    chk("pre_br_pc_d", pc_d, 32'h3010);
    br_taken = 1; br_imm = 16'hFFFC;
    tick();
    chk("brn_addr", imem_addr,   32'h3004);
    chk("brn_fl",   flush_d,     1);
    chk("brn_iv",   instr_valid, 1);
    chk("brn_pc_d", pc_d,        32'h3014);
    br_taken = 0;
    tick();
    chk("brn_fl_clr", flush_d,   0);
    chk("brn_next",   imem_addr, 32'h3008);
    chk("brn_pc_d2",  pc_d,      32'h3004);

    // forward branch from pc_d=3010
    tick(); tick(); tick();
    chk("pre_brp_pc_d", pc_d, 32'h3010);
    br_taken = 1; br_imm = 16'h0004;
    tick();
    chk("brp_addr", imem_addr, 32'h3024);
    chk("brp_fl",   flush_d,   1);

    // j and br together: j wins (pc_d=3014, index 0xC40 -> 3100)
    br_imm = 16'h0001; j_taken = 1; j_index = 26'h0000C40;
    tick();
    chk("j_addr", imem_addr, 32'h3100);
    chk("j_fl",   flush_d,   1);
    br_taken = 0; j_taken = 0;

    // jr while imem not ready: captured, applied on completion
    imem_ready = 0; jr_taken = 1; jr_target = 32'h0000_4000;
    tick();
    chk("pend1_addr", imem_addr,   32'h3100);
    chk("pend1_req",  imem_req,    1);
    chk("pend1_iv",   instr_valid, 0);
    tick();
    chk("pend2_addr", imem_addr, 32'h3100);
    jr_taken = 0; imem_ready = 1;
    tick();
    chk("pend_apply", imem_addr, 32'h4000);
    chk("pend_fl",    flush_d,   1);
    chk("pend_pc_d",  pc_d,      32'h3100);
    tick();
    chk("pend_clr",    imem_addr, 32'h4004);
    chk("pend_fl_clr", flush_d,   0);

    // 32-bit wrap of PC+4
    jr_taken = 1; jr_target = 32'hFFFF_FFFC;
    tick();
    chk("wrap_tgt", imem_addr, 32'hFFFF_FFFC);
    jr_taken = 0;
    tick();
    chk("wrap_addr", imem_addr, 32'h0);
    chk("wrap_pc_d", pc_d,      32'hFFFF_FFFC);

    // exception at pc_d=300C
    jr_taken = 1; jr_target = 32'h0000_3008;
    tick();
    jr_taken = 0;
    tick(); tick();
    chk("pre_exc_pc_d", pc_d, 32'h300C);
    exc_req = 1;
    tick();
    exc_req = 0;
    chk("exc_addr", imem_addr, exp_exc_addr);
    chk("exc_epc",  epc,       exp_exc_epc);
    chk("exc_fl",   flush_d,   exp_exc_fl);

    // halt is sticky
    halt = 1;
    tick();
    chk("halt_req",  imem_req,  0);
    chk("halt_addr", imem_addr, exp_exc_addr);
    halt = 0;
    tick(); tick();
    chk("halt_hold", imem_req, 0);

    // reset from halt, then reset asserted mid-fetch at 3020
    Reset = 0;
    tick();
    Reset = 1;
    tick();
    jr_taken = 1; jr_target = 32'h0000_3020;
    tick();
    jr_taken = 0; imem_ready = 0;
    tick();
    chk("mid_req",  imem_req,  1);
    chk("mid_addr", imem_addr, 32'h3020);
    #2;
    Reset = 0;
    #1;
    chk("rmid_req",  imem_req,    0);
    chk("rmid_addr", imem_addr,   32'h3000);
    chk("rmid_iv",   instr_valid, 0);
    chk("rmid_fl",   flush_d,     0);
    tick();
    Reset = 1; imem_ready = 1;
    tick();
    chk("post_req",  imem_req,  1);
    chk("post_addr", imem_addr, 32'h3000);
    tick();
    chk("post_pc_d", pc_d,        32'h3000);
    chk("post_next", imem_addr,   32'h3004);
    chk("post_iv",   instr_valid, 1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
